// File: rtl/oflow_prev_feature_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : oflow_prev_feature_feeder_if
// Brief    : Bus between the previous-frame feature feeder and one
//            similarity-metric PE. The feeder is the master and the PE is
//            the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface oflow_prev_feature_feeder_if #(
   parameter int FEAT_W  = 256,
   parameter int ID_W    = 8,
   parameter int SCORE_W = 32
);
   logic                pe_start;
   logic [FEAT_W-1:0]   pe_features;
   logic                pe_read_next;
   logic                pe_valid;
   logic [SCORE_W-1:0]  pe_score;
   logic [ID_W-1:0]     pe_id;

   modport master (
      output pe_start,
      output pe_features,
      input  pe_read_next,
      input  pe_valid,
      input  pe_score,
      input  pe_id
   );

   modport slave (
      input  pe_start,
      input  pe_features,
      output pe_read_next,
      output pe_valid,
      output pe_score,
      output pe_id
   );
endinterface
`default_nettype wire

// File: rtl/oflow_prev_feature_feeder.sv
`default_nettype none
// ============================================================================
// Module   : oflow_prev_feature_feeder
// Brief    : Buffers previous-frame feature lines and streams them one at a
//            time to a similarity PE. It prefetches the next line on the PE
//            read-new-line control and tracks the lowest score and its id.
// Revision : 1.0 - initial release
// ============================================================================
module oflow_prev_feature_feeder #(
   parameter int FEAT_W  = 256,
   parameter int ID_W    = 8,
   parameter int SCORE_W = 32,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset_N,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [FEAT_W-1:0]     wr_data,
   input  logic                  start,
   input  logic [ADDR_W:0]       num_prev,
   oflow_prev_feature_feeder_if.master pe,
   output logic                  busy,
   output logic                  done,
   output logic                  best_valid,
   output logic [SCORE_W-1:0]    best_score,
   output logic [ID_W-1:0]       best_id
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [FEAT_W-1:0]   mem [DEPTH];
   logic [FEAT_W-1:0]   staging;
   logic                staged;     // staging already holds line rd_ptr
   logic [ADDR_W:0]     count;
   logic [ADDR_W:0]     rd_ptr;     // index of the next line to hand to the PE
   logic [ADDR_W-1:0]   rd_addr;
   logic                more_lines;
   logic                better;

   assign rd_addr    = rd_ptr[ADDR_W-1:0];
   assign more_lines = (rd_ptr < count);
   // Strict compare so that a tie keeps the earlier line.
   assign better     = !best_valid || (pe.pe_score < best_score);

   // Buffer write port, open only while the feeder is idle.
   always_ff @(posedge clk) begin
      if (wr_en && (state == IDLE)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state control outputs.
   always_comb begin
      state_nxt   = state;
      pe.pe_start = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_prev == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            pe.pe_start = 1'b1;
            busy        = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (pe.pe_valid) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            busy      = 1'b1;
            state_nxt = more_lines ? ISSUE : DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line pointer, prefetch staging, feature register and best-score tracking.
   always_ff @(posedge clk) begin
      if (!reset_N) begin
         pe.pe_features <= '0;
         staging        <= '0;
         staged         <= 1'b0;
         count          <= '0;
         rd_ptr         <= '0;
         best_valid     <= 1'b0;
         best_score     <= '0;
         best_id        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count      <= num_prev;
                  best_valid <= 1'b0;
                  best_score <= '0;
                  best_id    <= '0;
                  staged     <= 1'b0;
                  if (num_prev != '0) begin
                     pe.pe_features <= mem[0];
                     rd_ptr         <= {{ADDR_W{1'b0}}, 1'b1};
                  end
               end
            end
            WAIT: begin
               // Only the first read-new-line request per line prefetches.
               if (pe.pe_read_next && !staged && more_lines) begin
                  staging <= mem[rd_addr];
                  staged  <= 1'b1;
               end
            end
            CAPTURE: begin
               if (better) begin
                  best_valid <= 1'b1;
                  best_score <= pe.pe_score;
                  best_id    <= pe.pe_id;
               end
               if (more_lines) begin
                  // Without a prefetch the buffer is read directly here.
                  pe.pe_features <= staged ? staging : mem[rd_addr];
                  rd_ptr         <= rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
                  staged         <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
